// File: rtl/el2_pkg.sv
// -----------------------------------------------------------------------------
// el2_pkg
// Shared types and constants for the LSU ECC writeback path.
//   EL2_DCCM_BITS / EL2_DCCM_DATA_WIDTH / EL2_DCCM_ECC_WIDTH : default DCCM geometry
//   ECC_WB_CNT_MAX      : saturation value of the completed-writeback counter
//   el2_ecc_wb_entry_t  : one queued writeback {addr, data}
//   ecc_wb_push_count() : number of queue entries a capture needs (0..2)
// -----------------------------------------------------------------------------
package el2_pkg;

   localparam int EL2_DCCM_BITS       = 16;
   localparam int EL2_DCCM_DATA_WIDTH = 32;
   localparam int EL2_DCCM_ECC_WIDTH  = 7;

   localparam logic [15:0] ECC_WB_CNT_MAX = 16'hFFFF;

   // The entry layout follows the package geometry; a top-level instance
   // must use the same DCCM widths.
   typedef struct packed {
      logic [EL2_DCCM_BITS-1:0]       addr;
      logic [EL2_DCCM_DATA_WIDTH-1:0] data;
   } el2_ecc_wb_entry_t;

   function automatic logic [1:0] ecc_wb_push_count(input logic lo, input logic hi);
      return {1'b0, lo} + {1'b0, hi};
   endfunction

endpackage

// File: rtl/el2_lsu_ecc_wb_fifo.sv
// -----------------------------------------------------------------------------
// el2_lsu_ecc_wb_fifo
// Writeback queue: DEPTH entries, two push ports (lo then hi) and one pop port.
//   clk, rst_l          clock, asynchronous active-low reset
//   i_push_lo/i_push_hi push requests for this cycle
//   i_lo_entry/i_hi_entry entries to push (lo lands first)
//   i_pop               pop the head (ignored when empty)
//   o_head              head entry, read directly from storage
//   o_empty             queue holds no entries
//   o_busy              registered: occupancy > DEPTH-2
//   o_drop              push requested but not enough free entries
// A push is all-or-nothing and free space is measured before any same-cycle
// pop, so a full queue never accepts a capture even while it is draining.
// -----------------------------------------------------------------------------
module el2_lsu_ecc_wb_fifo
   import el2_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 48
) (
   input  logic         clk,
   input  logic         rst_l,
   input  logic         i_push_lo,
   input  logic         i_push_hi,
   input  logic [W-1:0] i_lo_entry,
   input  logic [W-1:0] i_hi_entry,
   input  logic         i_pop,
   output logic [W-1:0] o_head,
   output logic         o_empty,
   output logic         o_busy,
   output logic         o_drop
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_occ;
   logic          r_busy;

   logic [1:0]    w_need;
   logic [CW-1:0] w_free;
   logic          w_accept;
   logic          w_pop;
   logic [PW-1:0] w_wr_ptr_p1;
   logic [W-1:0]  w_first_entry;
   logic [CW-1:0] w_occ_nxt;

   assign w_need   = ecc_wb_push_count(i_push_lo, i_push_hi);
   assign w_free   = CW'(DEPTH) - r_occ;
   assign w_accept = (w_need != 2'd0) && (CW'(w_need) <= w_free);
   assign o_drop   = (w_need != 2'd0) && !w_accept;
   assign w_pop    = i_pop && (r_occ != '0);

   // With both banks flagged lo takes the current slot and hi the next one.
   assign w_first_entry = i_push_lo ? i_lo_entry : i_hi_entry;
   assign w_wr_ptr_p1   = r_wr_ptr + PW'(1);

   assign w_occ_nxt = r_occ + (w_accept ? CW'(w_need) : CW'(0)) - CW'(w_pop);

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
         r_busy   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_mem[r_wr_ptr] <= w_first_entry;
            if (w_need == 2'd2) begin
               r_mem[w_wr_ptr_p1] <= i_hi_entry;
            end
            // Truncation to PW bits gives the modulo-DEPTH wrap.
            r_wr_ptr <= r_wr_ptr + PW'(w_need);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_occ  <= w_occ_nxt;
         r_busy <= (w_occ_nxt > CW'(DEPTH - 2));
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_empty = (r_occ == '0);
   assign o_busy  = r_busy;

endmodule

// File: rtl/rvecc_encode.sv
// -----------------------------------------------------------------------------
// rvecc_encode
// Hamming SECDED encoder for a 32-bit DCCM word (39,32 code).
//   din     in  32  data word
//   ecc_out out  7  check bits; [5:0] Hamming parities, [6] overall parity
// Data bits occupy the non-power-of-two codeword positions 3,5,6,7,9..;
// ecc_out[i] is the XOR of the data bits whose position has bit i set.
// -----------------------------------------------------------------------------
module rvecc_encode (
   input  logic [31:0] din,
   output logic [6:0]  ecc_out
);

   assign ecc_out[0] = din[0]^din[1]^din[3]^din[4]^din[6]^din[8]^din[10]^din[11]^
                       din[13]^din[15]^din[17]^din[19]^din[21]^din[23]^din[25]^
                       din[26]^din[28]^din[30];

   assign ecc_out[1] = din[0]^din[2]^din[3]^din[5]^din[6]^din[9]^din[10]^din[12]^
                       din[13]^din[16]^din[17]^din[20]^din[21]^din[24]^din[25]^
                       din[27]^din[28]^din[31];

   assign ecc_out[2] = din[1]^din[2]^din[3]^din[7]^din[8]^din[9]^din[10]^din[14]^
                       din[15]^din[16]^din[17]^din[22]^din[23]^din[24]^din[25]^
                       din[29]^din[30]^din[31];

   assign ecc_out[3] = (^din[10:4]) ^ (^din[25:18]);
   assign ecc_out[4] = ^din[25:11];
   assign ecc_out[5] = ^din[31:26];

   // Overall parity covers the data and the six Hamming bits.
   assign ecc_out[6] = (^din[31:0]) ^ (^ecc_out[5:0]);

endmodule

// File: rtl/el2_lsu_ecc_wb.sv
// -----------------------------------------------------------------------------
// el2_lsu_ecc_wb
// Scrubs single-bit DCCM errors: captures the corrected words seen at R stage
// and writes them back with fresh ECC through a request/grant port.
//   clk, rst_l                  clock, asynchronous active-low reset
//   dec_tlu_core_ecc_disable    blocks new captures (queue still drains)
//   err_valid_r/err_lo_r/err_hi_r  single-error report and flagged banks
//   lsu_addr_r/end_addr_r       lo/hi bank addresses
//   sec_data_lo_r/sec_data_hi_r corrected lo/hi words
//   wb_req/wb_gnt               writeback request / grant (pop on req & gnt)
//   wb_addr/wb_data/wb_ecc      head write address, data and its ECC
//   wb_busy                     fewer than two free entries
//   wb_ovf                      sticky: a capture was dropped
//   wb_cnt                      saturating completed-writeback count
//   wb_clr                      clears wb_ovf and wb_cnt (wins over updates)
// Handshake: wb_req is high whenever the queue holds an entry; the head and
// wb_req stay stable until a cycle with wb_gnt high, which pops the head.
// wb_gnt while wb_req is low has no effect.
// -----------------------------------------------------------------------------
module el2_lsu_ecc_wb
   import el2_pkg::*;
#(
   parameter int DCCM_BITS       = EL2_DCCM_BITS,
   parameter int DCCM_DATA_WIDTH = EL2_DCCM_DATA_WIDTH,
   parameter int DCCM_ECC_WIDTH  = EL2_DCCM_ECC_WIDTH,
   parameter int DEPTH           = 4
) (
   input  logic                       clk,
   input  logic                       rst_l,
   input  logic                       dec_tlu_core_ecc_disable,
   input  logic                       err_valid_r,
   input  logic                       err_lo_r,
   input  logic                       err_hi_r,
   input  logic [DCCM_BITS-1:0]       lsu_addr_r,
   input  logic [DCCM_BITS-1:0]       end_addr_r,
   input  logic [DCCM_DATA_WIDTH-1:0] sec_data_lo_r,
   input  logic [DCCM_DATA_WIDTH-1:0] sec_data_hi_r,
   output logic                       wb_req,
   input  logic                       wb_gnt,
   output logic [DCCM_BITS-1:0]       wb_addr,
   output logic [DCCM_DATA_WIDTH-1:0] wb_data,
   output logic [DCCM_ECC_WIDTH-1:0]  wb_ecc,
   output logic                       wb_busy,
   output logic                       wb_ovf,
   output logic [15:0]                wb_cnt,
   input  logic                       wb_clr
);

   localparam int ENTRY_W = $bits(el2_ecc_wb_entry_t);

   el2_ecc_wb_entry_t w_lo_entry;
   el2_ecc_wb_entry_t w_hi_entry;
   el2_ecc_wb_entry_t w_head;

   logic        w_capture;
   logic        w_push_lo;
   logic        w_push_hi;
   logic        w_empty;
   logic        w_drop;
   logic        w_pop;
   logic        r_ovf;
   logic [15:0] r_cnt;

   assign w_capture = err_valid_r & ~dec_tlu_core_ecc_disable;
   assign w_push_lo = w_capture & err_lo_r;
   assign w_push_hi = w_capture & err_hi_r;

   // DCCM writes are whole bank words, so drop the byte offset.
   assign w_lo_entry.addr = {lsu_addr_r[DCCM_BITS-1:2], 2'b00};
   assign w_lo_entry.data = sec_data_lo_r;
   assign w_hi_entry.addr = {end_addr_r[DCCM_BITS-1:2], 2'b00};
   assign w_hi_entry.data = sec_data_hi_r;

   el2_lsu_ecc_wb_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk        (clk),
      .rst_l      (rst_l),
      .i_push_lo  (w_push_lo),
      .i_push_hi  (w_push_hi),
      .i_lo_entry (w_lo_entry),
      .i_hi_entry (w_hi_entry),
      .i_pop      (w_pop),
      .o_head     (w_head),
      .o_empty    (w_empty),
      .o_busy     (wb_busy),
      .o_drop     (w_drop)
   );

   assign wb_req  = ~w_empty;
   assign w_pop   = wb_req & wb_gnt;
   assign wb_addr = w_head.addr;
   assign wb_data = w_head.data;

   rvecc_encode u_ecc (
      .din     (wb_data),
      .ecc_out (wb_ecc)
   );

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_ovf <= 1'b0;
         r_cnt <= '0;
      end else if (wb_clr) begin
         r_ovf <= 1'b0;
         r_cnt <= '0;
      end else begin
         if (w_drop) begin
            r_ovf <= 1'b1;
         end
         if (w_pop && (r_cnt != ECC_WB_CNT_MAX)) begin
            r_cnt <= r_cnt + 16'd1;
         end
      end
   end

   assign wb_ovf = r_ovf;
   assign wb_cnt = r_cnt;

endmodule

// File: doc/el2_lsu_ecc_wb.md
# el2_lsu_ecc_wb

Corrected-data writeback engine for the DCCM. It captures the single-bit-corrected words produced by the LSU ECC decode path at R stage and queues them. It then writes them back to the DCCM through a request/grant port, with freshly generated ECC, so the stored error is scrubbed. It sits between the LSU ECC block and the DCCM write-port arbiter, on the write side of the same ECC protocol the decode path reads.

## Interface
Parameters:
- DCCM_BITS, 16, DCCM byte-address width
- DCCM_DATA_WIDTH, 32, bank word width
- DCCM_ECC_WIDTH, 7, ECC check-bit width
- DEPTH, 4, queue entries (power of two, ≥2)

Ports:
- clk  in  1  core clock; one clock domain
- rst_l  in  1  reset, asynchronous, active-low
- dec_tlu_core_ecc_disable  in  1  when 1, new captures are dropped; the queue still drains
- err_valid_r  in  1  committed load at R had a single ECC error
- err_lo_r  in  1  lo bank corrected
- err_hi_r  in  1  hi bank corrected
- lsu_addr_r  in  DCCM_BITS  start address (lo bank word)
- end_addr_r  in  DCCM_BITS  end address (hi bank word)
- sec_data_lo_r  in  DCCM_DATA_WIDTH  corrected lo word
- sec_data_hi_r  in  DCCM_DATA_WIDTH  corrected hi word
- wb_req  out  1  writeback request
- wb_gnt  in  1  DCCM write port granted this cycle
- wb_addr  out  DCCM_BITS  word-aligned write address
- wb_data  out  DCCM_DATA_WIDTH  write data
- wb_ecc  out  DCCM_ECC_WIDTH  ECC of wb_data
- wb_busy  out  1  fewer than 2 free entries; the LSU uses it to hold off loads
- wb_ovf  out  1  sticky; a capture was dropped because the queue was full
- wb_cnt  out  16  saturating count of completed writebacks
- wb_clr  in  1  clears wb_ovf and wb_cnt

## Operation
- Capture condition: err_valid_r & ~dec_tlu_core_ecc_disable.
- Each capture pushes one entry per flagged bank. Entry = {addr, data}.
- The lo entry uses {lsu_addr_r[DCCM_BITS-1:2],2'b00} and sec_data_lo_r. The hi entry uses {end_addr_r[DCCM_BITS-1:2],2'b00} and sec_data_hi_r.
- When both banks are flagged, lo is enqueued first, then hi, in the same cycle.
- Capture is all-or-nothing:
  - If the number of free entries (counted before any same-cycle pop) is less than the number of entries to push, nothing is written.
  - In that case wb_ovf sets. wb_cnt is unaffected.
- err_valid_r with neither bank flag set is a no-op.
- wb_req = queue not empty. wb_addr and wb_data come from the queue head, straight from storage flops, with no comb path from capture inputs.
- wb_ecc is computed combinationally from wb_data by the standard Hamming encoder.
- Handshake:
  - wb_req & wb_gnt pops the head.
  - While wb_gnt is low, wb_req, wb_addr and wb_data hold stable.
  - wb_gnt without wb_req is ignored.
- Occupancy counter is 0..DEPTH. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- A push and a pop in the same cycle are both performed.
- wb_cnt increments on each pop and saturates at 16'hFFFF.
- wb_clr has priority over an increment and over an overflow set in the same cycle: the result is 0.
- dec_tlu_core_ecc_disable blocks capture only. Pending entries still write back.

## Timing
- Reset values: wb_req=0, wb_addr=0, wb_data=0, wb_busy=0, wb_ovf=0, wb_cnt=0, pointers=0, occupancy=0.
- wb_ecc at reset equals the ECC of all-zero data, which is 7'h00.
- Capture at edge N puts wb_req=1 in cycle N+1 if the queue was empty.
- One writeback per cycle maximum. Back-to-back grants drain DEPTH entries in DEPTH cycles.
- wb_busy is registered from occupancy: it is 1 when occupancy > DEPTH-2 after the edge.
- wb_ovf sets the cycle after the dropped capture.
- An asserted reset mid-operation empties the queue asynchronously, even if a grant is pending. No partial write is reissued.

## Structure
- Shared package el2_pkg:
  - typedef el2_ecc_wb_entry_t {addr[DCCM_BITS-1:0], data[DCCM_DATA_WIDTH-1:0]}
  - constant ECC_WB_CNT_MAX = 16'hFFFF
- Sub-module el2_lsu_ecc_wb_fifo holds entries, pointers and occupancy. It provides dual push ports (lo, hi) and one pop port.
- Reuse the existing rvecc_encode for wb_ecc. Do not write a new encoder.

## Test plan
- Reset, then idle → all outputs 0, wb_ecc=7'h00; wb_gnt pulses are ignored.
- err_valid_r, err_lo_r=1, lsu_addr_r=16'h0106, sec_data_lo_r=32'hDEADBEEF, wb_gnt=1 → next cycle wb_req=1, wb_addr=16'h0104, wb_data=32'hDEADBEEF, wb_ecc=rvecc_encode(32'hDEADBEEF); entry pops; wb_cnt=1.
- Dual error (lsu_addr_r=16'h0004, end_addr_r=16'h0008), wb_gnt low 3 cycles then high → lo entry (16'h0004) held stable, then lo and hi (16'h0008) write on consecutive cycles; wb_cnt=2.
- Four single captures with wb_gnt=0, then a fifth → wb_busy=1 after the third; the fifth is dropped and wb_ovf=1; the drain yields exactly the first four addresses in order.
- Capture while queue full and wb_gnt=1 in the same cycle → capture dropped because free space is counted before the pop; the pop completes.
- dec_tlu_core_ecc_disable=1 with one entry pending and a new capture → pending entry written; new capture ignored; wb_ovf stays 0.
- wb_cnt preloaded to 16'hFFFF via drains, one more pop → stays 16'hFFFF. wb_clr together with a pop → wb_cnt=0.
